bloco_controle: RTL

Control block (BC) that sequences the operative block BO to evaluate y = A·x² + B·x + C using Horner form ((A·x + B)·x + C).
- Drives every BO control input: LX, M0, M1, M2, H, LH, LS.
- Uses a start/done handshake toward the system.
- A per-step hold counter absorbs the clocked latency of the muxes and SomaMultiplica before each register load.

---
 rtl/bloco_controle.sv | 112 +++++++++++
 1 files changed

// File: rtl/bloco_controle.sv
// Horner-form sequencer for the operative block: y = (A*x + B)*x + C.
// Every control output is a registered Moore decode of the state and the hold counter.
module bloco_controle #(
  parameter int unsigned LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       LX,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       H,
  output logic       LH,
  output logic       LS,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOADX = 3'd1;
  localparam logic [2:0] S1    = 3'd2;
  localparam logic [2:0] S2    = 3'd3;
  localparam logic [2:0] S3    = 3'd4;
  localparam logic [2:0] S4    = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [3:0] LAT_C = LAT[3:0];

  logic [2:0] r_state;
  logic [3:0] r_cnt;
  logic [2:0] w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_step_end;

  logic       w_lx, w_h, w_lh, w_ls, w_busy, w_done;
  logic [1:0] w_m0, w_m1, w_m2;

  assign w_step_end = (r_cnt == LAT_C);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      IDLE:  if (start) w_state_nxt = LOADX;
      LOADX: w_state_nxt = S1;
      S1, S2, S3, S4: begin
        // S4 + 1 encodes DONE, so the step chain advances by increment
        if (w_step_end) w_state_nxt = r_state + 3'd1;
        else            w_cnt_nxt   = r_cnt + 4'd1;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_lx   = (r_state == LOADX);
    w_busy = (r_state >= LOADX) && (r_state <= S4);
    w_done = (r_state == DONE);
    w_m0   = '0;
    w_m1   = '0;
    w_m2   = '0;
    w_h    = 1'b0;
    w_lh   = 1'b0;
    w_ls   = 1'b0;
    case (r_state)
      S1: begin
        w_m0 = 2'b01; w_m1 = 2'b00; w_m2 = 2'b00; w_h = 1'b1; w_lh = w_step_end;
      end
      S2: begin
        w_m0 = 2'b10; w_m1 = 2'b10; w_m2 = 2'b01; w_h = 1'b0; w_lh = w_step_end;
      end
      S3: begin
        w_m0 = 2'b00; w_m1 = 2'b10; w_m2 = 2'b00; w_h = 1'b1; w_lh = w_step_end;
      end
      S4: begin
        w_m0 = 2'b11; w_m1 = 2'b10; w_m2 = 2'b01; w_h = 1'b0; w_ls = w_step_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      LX      <= 1'b0;
      M0      <= '0;
      M1      <= '0;
      M2      <= '0;
      H       <= 1'b0;
      LH      <= 1'b0;
      LS      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      LX      <= w_lx;
      M0      <= w_m0;
      M1      <= w_m1;
      M2      <= w_m2;
      H       <= w_h;
      LH      <= w_lh;
      LS      <= w_ls;
      busy    <= w_busy;
      done    <= w_done;
    end
  end

endmodule
